booth_mul_seq: RTL and testbench

//  Parametrised sequential radix-2 Booth multiplier for the arithmetic processor datapath.
//  - Supersedes the fixed 8-bit unit.
//  - Adds WIDTH generalisation and a per-operation signed/unsigned mode.
//  - Start/Busy/Done handshake and a registered product that is stable between operations.
//  - Sits beside the ALU; the control unit issues Start and waits for Done.

---
 rtl/arith_pkg.sv | 11 +
 rtl/booth_addsub.sv | 15 +
 rtl/booth_mul_seq.sv | 98 +++++++++
 tb/tb_booth_mul_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: sequencer state encoding for the
// multi-cycle arithmetic units.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_addsub.sv
// Combinational W-bit adder/subtractor for the Booth step; carry-out is dropped.
module booth_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  always_comb begin
    y = sub ? (a + ~b + W'(1)) : (a + b);
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation,
// with a Start/Busy/Done handshake and a product register held between operations.
module booth_mul_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy,
  output logic                 Done
);

  // One guard bit lets unsigned max and the most negative signed value run exactly.
  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(E - 1);

  state_t          state_reg;
  logic [E-1:0]    a_reg;
  logic [E-1:0]    m_reg;
  logic [E-1:0]    q_reg;
  logic            q_1_reg;
  logic [CW-1:0]   count_reg;

  logic [E-1:0]    sum;
  logic [E-1:0]    a_step;
  logic [E-1:0]    a_sh;
  logic [E-1:0]    q_sh;

  booth_addsub #(.W(E)) u_addsub (
    .a   (a_reg),
    .b   (m_reg),
    .sub (q_reg[0]),
    .y   (sum)
  );

  // Pairs 01 add, 10 subtract; 00/11 leave A alone. Then shift {A,Q,Q_1} right arithmetically.
  always_comb begin
    a_step = (q_reg[0] ^ q_1_reg) ? sum : a_reg;
    a_sh   = {a_step[E-1], a_step[E-1:1]};
    q_sh   = {a_step[0], q_reg[E-1:1]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      q_1_reg   <= 1'b0;
      count_reg <= '0;
      Product   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (Start) begin
            a_reg     <= '0;
            m_reg     <= {Signed & Multiplicand[WIDTH-1], Multiplicand};
            q_reg     <= {Signed & Multiplier[WIDTH-1], Multiplier};
            q_1_reg   <= 1'b0;
            count_reg <= '0;
            state_reg <= RUN;
            Busy      <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_reg     <= a_sh;
          q_reg     <= q_sh;
          q_1_reg   <= q_reg[0];
          count_reg <= count_reg + CW'(1);
          if (count_reg == LAST_STEP) begin
            // The two top bits of {A,Q} are pure sign/guard copies after the final shift.
            Product   <= {a_sh[E-3:0], q_sh};
            state_reg <= DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq at WIDTH=8 and WIDTH=16: latency, handshake,
// corner operands, ignored Start, back-to-back operation and asynchronous reset.
module tb_booth_mul_seq;

  logic        CLK = 1'b0;
  logic        RST;
  always #5 CLK = ~CLK;

  logic        start8, sg8, busy8, done8;
  logic [7:0]  mc8, mq8;
  logic [15:0] prod8;

  logic        start16, sg16, busy16, done16;
  logic [15:0] mc16, mq16;
  logic [31:0] prod16;

  int errors = 0;
  int checks = 0;

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .Start(start8), .Signed(sg8),
    .Multiplicand(mc8), .Multiplier(mq8),
    .Product(prod8), .Busy(busy8), .Done(done8)
  );

  booth_mul_seq #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RST(RST), .Start(start16), .Signed(sg16),
    .Multiplicand(mc16), .Multiplier(mq16),
    .Product(prod16), .Busy(busy16), .Done(done16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference product for the random 16-bit vectors.
  function automatic logic [31:0] ref16(input logic sg, input logic [15:0] m, input logic [15:0] q);
    longint a, b;
    a = sg ? longint'($signed(m)) : longint'(m);
    b = sg ? longint'($signed(q)) : longint'(q);
    return 32'(a * b);
  endfunction

  // One 8-bit operation; if poke>=0 a spurious Start with other operands is raised mid-run.
  task automatic op8(input string tag, input logic sg, input logic [7:0] m, input logic [7:0] q,
                     input logic [15:0] exp, input int poke);
    int  cyc;
    bit  seen;
    @(negedge CLK);
    sg8 = sg; mc8 = m; mq8 = q; start8 = 1'b1;
    @(posedge CLK); #1;
    start8 = 1'b0;
    check({tag, "_busy_start"}, 64'(busy8), 64'd1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 30) begin
      if (cyc == poke) begin
        start8 = 1'b1; sg8 = ~sg; mc8 = ~m; mq8 = 8'h55;
      end
      @(posedge CLK); #1;
      start8 = 1'b0;
      cyc++;
      if (done8) seen = 1;
      else check({tag, "_busy_run"}, 64'(busy8), 64'd1);
    end
    check({tag, "_latency"}, 64'(cyc), 64'd9);
    check({tag, "_product"}, 64'(prod8), 64'(exp));
    check({tag, "_busy_done"}, 64'(busy8), 64'd0);
    @(posedge CLK); #1;
    check({tag, "_done_pulse"}, 64'(done8), 64'd0);
    check({tag, "_product_hold"}, 64'(prod8), 64'(exp));
    $display("op8  %s sg=%0d m=%h q=%h product=%h cycles=%0d", tag, sg, m, q, prod8, cyc);
  endtask

  task automatic op16(input string tag, input logic sg, input logic [15:0] m, input logic [15:0] q,
                      input logic [31:0] exp);
    int cyc;
    bit seen;
    @(negedge CLK);
    sg16 = sg; mc16 = m; mq16 = q; start16 = 1'b1;
    @(posedge CLK); #1;
    start16 = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (done16) seen = 1;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd17);
    check({tag, "_product"}, 64'(prod16), 64'(exp));
    $display("op16 %s sg=%0d m=%h q=%h product=%h cycles=%0d", tag, sg, m, q, prod16, cyc);
  endtask

  initial begin
    int ndone;
    logic [15:0] rm, rq;
    logic        rs;

    RST = 1'b1;
    start8 = 0; sg8 = 0; mc8 = '0; mq8 = '0;
    start16 = 0; sg16 = 0; mc16 = '0; mq16 = '0;
    #12;
    check("rst_product8", 64'(prod8), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_product16", 64'(prod16), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    op8("s_3x-2",      1'b1, 8'h03, 8'hFE, 16'hFFFA, -1);
    op8("u_ffxff",     1'b0, 8'hFF, 8'hFF, 16'hFE01, -1);
    op8("s_ffxff",     1'b1, 8'hFF, 8'hFF, 16'h0001, -1);
    op8("s_80x80",     1'b1, 8'h80, 8'h80, 16'h4000, -1);
    op8("s_80x7f",     1'b1, 8'h80, 8'h7F, 16'hC080, -1);
    op8("u_80x7f",     1'b0, 8'h80, 8'h7F, 16'h3F80, -1);
    op8("u_03xfe",     1'b0, 8'h03, 8'hFE, 16'h02FA, -1);
    op8("ignore_start",1'b1, 8'h03, 8'hFE, 16'hFFFA, 2);

    // Start held across the Done cycle: second operation loads in the DONE state.
    @(negedge CLK);
    sg8 = 1'b1; mc8 = 8'h03; mq8 = 8'hFE; start8 = 1'b1;
    @(posedge CLK); #1;
    sg8 = 1'b0; mc8 = 8'h0C; mq8 = 8'h0A;
    ndone = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge CLK); #1;
      if (c == 10) begin
        start8 = 1'b0;
        check("b2b_busy_nogap", 64'(busy8), 64'd1);
      end
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          check("b2b_first_cycle", 64'(c), 64'd9);
          check("b2b_first_product", 64'(prod8), 64'hFFFA);
        end else begin
          check("b2b_second_cycle", 64'(c), 64'd19);
          check("b2b_second_product", 64'(prod8), 64'h0078);
        end
      end
    end
    check("b2b_done_count", 64'(ndone), 64'd2);
    $display("op8  b2b done_pulses=%0d product=%h", ndone, prod8);

    op16("s16_3x-2",   1'b1, 16'h0003, 16'hFFFE, 32'hFFFFFFFA);
    op16("u16_ffffsq", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    op16("s16_ffffsq", 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
    op16("s16_minsq",  1'b1, 16'h8000, 16'h8000, 32'h40000000);
    op16("s16_minmax", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
    for (int i = 0; i < 6; i++) begin
      rm = 16'($urandom);
      rq = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      op16($sformatf("r16_%0d", i), rs, rm, rq, ref16(rs, rm, rq));
    end

    // Asynchronous reset between clock edges during a run.
    @(negedge CLK);
    sg8 = 1'b1; mc8 = 8'h11; mq8 = 8'h22; start8 = 1'b1;
    @(posedge CLK); #1;
    start8 = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("arst_busy", 64'(busy8), 64'd0);
    check("arst_done", 64'(done8), 64'd0);
    check("arst_product8", 64'(prod8), 64'd0);
    check("arst_product16", 64'(prod16), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("arst_no_done", 64'(done8), 64'd0);
    $display("reset mid-run busy=%0d done=%0d product=%h", busy8, done8, prod8);
    op8("after_rst", 1'b1, 8'h7F, 8'h7F, 16'h3F01, -1);
    op16("after_rst16", 1'b0, 16'h1234, 16'h0010, 32'h00012340);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
